// File: rtl/id_ex_stage_if.sv
// ID-to-EX boundary bundle: decode-side inputs and the latched EX-side fields.
// master = decode/upstream driver, slave = the id_ex_stage register itself.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          ihit;
    logic          mem_busy;
    logic          flush;
    logic [RW-1:0] rs_i;
    logic [RW-1:0] rt_i;
    logic [RW-1:0] rd_i;
    logic [5:0]    opcode_i;
    logic [5:0]    funct_i;
    logic [15:0]   imm_i;
    logic [1:0]    reg_dest_i;
    logic          uses_rt_i;
    logic          WEN_i;
    logic [DW-1:0] rdat1_i;
    logic [DW-1:0] rdat2_i;
    logic [DW-1:0] pc4_i;

    logic [RW-1:0] rs_o;
    logic [RW-1:0] rt_o;
    logic [5:0]    opcode_o;
    logic [5:0]    funct_o;
    logic [1:0]    reg_dest_o;
    logic [RW-1:0] wsel_o;
    logic          WEN_o;
    logic [15:0]   imm_o;
    logic [DW-1:0] rdat1_o;
    logic [DW-1:0] rdat2_o;
    logic [DW-1:0] pc4_o;
    logic          valid_o;
    logic          stall_o;
    logic [31:0]   bubble_cnt_o;

    modport master (
        output ihit, mem_busy, flush, rs_i, rt_i, rd_i, opcode_i, funct_i, imm_i,
               reg_dest_i, uses_rt_i, WEN_i, rdat1_i, rdat2_i, pc4_i,
        input  rs_o, rt_o, opcode_o, funct_o, reg_dest_o, wsel_o, WEN_o, imm_o,
               rdat1_o, rdat2_o, pc4_o, valid_o, stall_o, bubble_cnt_o
    );

    modport slave (
        input  ihit, mem_busy, flush, rs_i, rt_i, rd_i, opcode_i, funct_i, imm_i,
               reg_dest_i, uses_rt_i, WEN_i, rdat1_i, rdat2_i, pc4_i,
        output rs_o, rt_o, opcode_o, funct_o, reg_dest_o, wsel_o, WEN_o, imm_o,
               rdat1_o, rdat2_o, pc4_o, valid_o, stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble; optional bubble counter via ID_EX_BUBBLE_CNT_EN.
// Latency: 1 advancing cycle ID->EX; stall_o is combinational from the latched load and ID indices.
// Backpressure: holds everything while ~ihit or mem_busy; flush/stall latch a zero bubble on advance.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic        CLK,
    input  logic        RST,
    id_ex_stage_if.slave bus
);
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [1:0] SEL_RT = 2'd1;
    localparam logic [1:0] SEL_31 = 2'd2;

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic [5:0]    opcode;
        logic [5:0]    funct;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] wsel;
        logic [1:0]    reg_dest;
        logic [15:0]   imm;
        logic [DW-1:0] rdat1;
        logic [DW-1:0] rdat2;
        logic [DW-1:0] pc4;
    } stage_t;

    stage_t        stage_q, stage_d;
    logic          adv;
    logic          hazard;
    logic [RW-1:0] wsel_in;

    always_comb begin
        adv = bus.ihit & ~bus.mem_busy;
        // Only a valid load writing a nonzero register can starve the next instruction.
        hazard = stage_q.valid && stage_q.wen && (stage_q.wsel != '0)
              && ((stage_q.opcode == OP_LW) || (stage_q.opcode == OP_LL))
              && ((stage_q.wsel == bus.rs_i) || (bus.uses_rt_i && (stage_q.wsel == bus.rt_i)));

        case (bus.reg_dest_i)
            SEL_RT:  wsel_in = bus.rt_i;
            SEL_31:  wsel_in = RW'(31);
            default: wsel_in = bus.rd_i;
        endcase

        stage_d = stage_q;
        if (adv) begin
            if (bus.flush || hazard) begin
                stage_d = '0;
            end else begin
                stage_d.valid    = 1'b1;
                stage_d.wen      = bus.WEN_i;
                stage_d.opcode   = bus.opcode_i;
                stage_d.funct    = bus.funct_i;
                stage_d.rs       = bus.rs_i;
                stage_d.rt       = bus.rt_i;
                stage_d.wsel     = wsel_in;
                stage_d.reg_dest = bus.reg_dest_i;
                stage_d.imm      = bus.imm_i;
                stage_d.rdat1    = bus.rdat1_i;
                stage_d.rdat2    = bus.rdat2_i;
                stage_d.pc4      = bus.pc4_i;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) stage_q <= '0;
        else     stage_q <= stage_d;
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (adv && (bus.flush || hazard) && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) bubble_cnt_q <= '0;
        else     bubble_cnt_q <= bubble_cnt_d;
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
`else
    assign bus.bubble_cnt_o = '0;
`endif

    // A flushed ID slot is squashed upstream, so it must not also freeze the PC.
    assign bus.stall_o    = hazard & ~bus.flush;
    assign bus.valid_o    = stage_q.valid;
    assign bus.WEN_o      = stage_q.wen;
    assign bus.opcode_o   = stage_q.opcode;
    assign bus.funct_o    = stage_q.funct;
    assign bus.rs_o       = stage_q.rs;
    assign bus.rt_o       = stage_q.rt;
    assign bus.wsel_o     = stage_q.wsel;
    assign bus.reg_dest_o = stage_q.reg_dest;
    assign bus.imm_o      = stage_q.imm;
    assign bus.rdat1_o    = stage_q.rdat1;
    assign bus.rdat2_o    = stage_q.rdat2;
    assign bus.pc4_o      = stage_q.pc4;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath, with load-use hazard detection.
- Latches decoded fields, register-file data and control from decode. Feeds EX and the forwarding unit with rs/rt, opcode, reg_dest, WEN and the resolved write register.
- Detects load-use hazards that forwarding cannot cover, stalls upstream and inserts a one-cycle bubble.
- Honours branch/jump flush and memory-wait freeze.

Parameters:
- DW, 32, datapath width of register data, immediate extension and PC.
- RW, 5, register-index width.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- ihit  in  1  instruction fetched this cycle; the pipeline may advance
- mem_busy  in  1  MEM stage waiting on dhit; freezes this register
- flush  in  1  squash the instruction in ID (branch/jump resolved)
- rs_i, rt_i, rd_i  in  RW each  decoded register indices
- opcode_i  in  6  decoded opcode
- funct_i  in  6  decoded funct
- imm_i  in  16  immediate
- reg_dest_i  in  2  write-register select: SEL_RD, SEL_RT, SEL_31
- uses_rt_i  in  1  ID instruction reads rt (R-type, SW, SC, BEQ, BNE)
- WEN_i  in  1  register write enable
- rdat1_i, rdat2_i  in  DW  register-file read data
- pc4_i  in  DW  PC+4
- rs_o, rt_o  out  RW  latched indices (forwarding-unit rs/rt)
- opcode_o  out  6  latched opcode (opcode_ID_EX)
- funct_o  out  6  latched funct
- reg_dest_o  out  2  latched select (reg_dest_ID_EX)
- wsel_o  out  RW  resolved write register: rd, rt or 31 per reg_dest
- WEN_o  out  1  latched write enable
- imm_o  out  16  latched immediate
- rdat1_o, rdat2_o  out  DW  latched data
- pc4_o  out  DW  latched PC+4
- valid_o  out  1  latched slot holds a real instruction
- stall_o  out  1  combinational: freeze PC and IF/ID this cycle
- bubble_cnt_o  out  32  bubble counter (see Optional Feature)

Behaviour:
- adv = ihit & ~mem_busy. Registers update only when adv=1; otherwise every output holds.
- Reset (RST=1 at edge): all outputs 0. This includes valid_o, WEN_o, opcode_o, wsel_o and bubble_cnt_o. Reset overrides adv and flush.
- Load-use detect (combinational):
  - Asserted when valid_o=1, opcode_o is LW or LL, WEN_o=1, and wsel_o!=0.
  - And either wsel_o==rs_i, or (uses_rt_i=1 and wsel_o==rt_i).
  - When asserted: stall_o=1; otherwise stall_o=0.
  - stall_o is gated by flush: flush=1 forces stall_o=0.
- On an adv edge, priority is flush > stall > load.
  - Flush or stall latches a bubble: valid=0, WEN=0, opcode=0, funct=0, rs=rt=rd=0, reg_dest=0, wsel=0, data/imm/pc4=0.
  - Load: capture all *_i and set valid=1. wsel_o is computed from rd_i/rt_i/31 before latching, so wsel_o is a registered output.
- Latency: 1 adv cycle ID->EX.
- Load-use stall lasts exactly one adv cycle: the bubble clears the hazard term, so the held ID instruction loads on the next adv.
- Stall while frozen: if mem_busy=1 with a hazard pending, stall_o stays 1 until an adv edge consumes it.
- Flush while frozen: not applied until adv; the upstream block holds flush until then.
- Simultaneous flush and load-use: bubble latched, stall_o=0, and ID is squashed by the upstream flush.
- Reset mid-stall: state cleared; stall_o=0 on the following cycle.
- Bubble outputs rs=rt=0, so the forwarding unit's !=0 guards select no forwarding.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt_o increments by 1 on each adv edge that latches a bubble due to stall or flush.
  - Saturates at 0xFFFFFFFF.
  - Cleared by RST.
- Undefined: counter logic absent; bubble_cnt_o tied to 0.

Test Plan:
- Reset: RST=1 for 2 cycles with arbitrary inputs -> all outputs 0, stall_o=0.
- Normal pass: ihit=1, ADDU rs=2 rt=3 rd=4 reg_dest=SEL_RD WEN=1 rdat1=0x11 rdat2=0x22 -> next cycle rs_o=2 rt_o=3 wsel_o=4 rdat1_o=0x11 rdat2_o=0x22 valid_o=1.
- Load-use: LW rt=5 latched; ID holds ADDU rs=5 -> stall_o=1. Next edge latches bubble (valid_o=0, WEN_o=0). Following edge latches ADDU with stall_o=0. Counter +1 when enabled.
- No false stall:
  - LW rt=0 followed by ADDU rs=0 -> stall_o=0.
  - LW rt=5 followed by ADDI rs=1 rt=5 uses_rt=0 -> stall_o=0.
- Freeze: mem_busy=1 for 3 cycles with new ID inputs -> outputs unchanged. On mem_busy=0 and ihit=1 -> the current inputs load.
- Flush plus hazard: LW rt=7 latched, ID rs=7, flush=1 -> stall_o=0. Next edge latches bubble. Counter +1 when enabled.
